// File: rtl/regfile_mp_sb.sv
// Multi-port register file with a pending-reservation scoreboard, an optional
// write-to-read bypass and a sequential bulk-clear engine.
// It sits between decode (reads and reservations) and writeback (writes).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rd_addr, rd_data    packed combinational read ports (port i at slot i)
//   rd_pend             per read port: the addressed register is reserved
//   we, wr_addr, wr_data     writeback port
//   rsv_valid, rsv_addr      reservation (mark pending) from issue
//   clr_req, clr_busy        bulk-clear request pulse and sweep-in-progress flag
module regfile_mp_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     we,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_valid,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     clr_req,
    output logic                     clr_busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t                state;
    logic [AW-1:0]         idx;
    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pend;

    logic idle;
    logic wr_ok;
    logic rsv_ok;

    // Register 0 is hard-wired when ZERO_REG is set: writes and reservations
    // to it are qualified away here so every consumer sees the same rule.
    assign idle   = (state == IDLE);
    assign wr_ok  = we && !((ZERO_REG != 0) && (wr_addr == '0));
    assign rsv_ok = rsv_valid && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Combinational read ports with optional same-cycle write forwarding.
    for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          bypass_hit;

        assign addr       = rd_addr[g*AW +: AW];
        assign is_zero    = (ZERO_REG != 0) && (addr == '0);
        assign bypass_hit = (BYPASS != 0) && wr_ok && idle && (wr_addr == addr);

        assign rd_data[g*DATA_W +: DATA_W] = is_zero    ? '0 :
                                             bypass_hit ? wr_data :
                                                          regs[addr];
        // Pending status is never forwarded: it reflects registered state only.
        assign rd_pend[g] = is_zero ? 1'b0 : pend[addr];
    end

    // Register array, scoreboard and clear FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
            pend     <= '0;
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                regs[r] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        // Clear wins over a coincident write or reservation.
                        state    <= SWEEP;
                        idx      <= '0;
                        clr_busy <= 1'b1;
                        pend     <= '0;
                    end else begin
                        if (wr_ok) begin
                            regs[wr_addr] <= wr_data;
                        end
                        if (we) begin
                            pend[wr_addr] <= 1'b0;
                        end
                        // Issued after the retire clear so a new producer on the
                        // same register keeps it pending.
                        if (rsv_ok) begin
                            pend[rsv_addr] <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    regs[idx] <= '0;
                    if (idx == LAST_IDX) begin
                        state    <= IDLE;
                        idx      <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    idx      <= '0;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus randomized
// traffic, compared against a behavioural model of the register file.
module tb_regfile_mp_sb;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned NUM_RD   = 2;
    localparam int unsigned AW       = 5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data, rd_data_nb;
    logic [NUM_RD-1:0]        rd_pend, rd_pend_nb;
    logic                     we;
    logic [AW-1:0]            wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     rsv_valid;
    logic [AW-1:0]            rsv_addr;
    logic                     clr_req;
    logic                     clr_busy, clr_busy_nb;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    bit                m_pend [NUM_REGS];
    bit                m_busy;
    int                m_sweep;

    always #5 clk = ~clk;

    regfile_mp_sb #(.BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_pend(rd_pend), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .clr_req(clr_req),
        .clr_busy(clr_busy)
    );

    regfile_mp_sb #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_pend(rd_pend_nb), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .clr_req(clr_req),
        .clr_busy(clr_busy_nb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input logic [AW-1:0] a, input bit bypass);
        if (a == 0) return '0;
        if (bypass && we && !m_busy && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_pend(input logic [AW-1:0] a);
        return (a == 0) ? 1'b0 : m_pend[a];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
        m_busy  = 1'b0;
        m_sweep = 0;
    endtask

    task automatic model_edge();
        if (!m_busy) begin
            if (clr_req) begin
                m_busy  = 1'b1;
                m_sweep = 0;
                for (int r = 0; r < int'(NUM_REGS); r++) m_pend[r] = 1'b0;
            end else begin
                if (we && wr_addr != 0) m_regs[wr_addr] = wr_data;
                if (we) m_pend[wr_addr] = 1'b0;
                if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
            end
        end else begin
            m_regs[m_sweep] = '0;
            m_sweep++;
            if (m_sweep == int'(NUM_REGS)) m_busy = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int p = 0; p < int'(NUM_RD); p++) begin
            logic [AW-1:0] a;
            a = rd_addr[p*AW +: AW];
            check({tag, "_rd"},    64'(rd_data[p*DATA_W +: DATA_W]),    64'(exp_rd(a, 1'b1)));
            check({tag, "_rd_nb"}, 64'(rd_data_nb[p*DATA_W +: DATA_W]), 64'(exp_rd(a, 1'b0)));
            check({tag, "_pend"},  64'(rd_pend[p]),  64'(exp_pend(a)));
        end
        check({tag, "_busy"}, 64'(clr_busy), 64'(m_busy));
        check({tag, "_busy_nb"}, 64'(clr_busy_nb), 64'(m_busy));
    endtask

    // Inputs are set by the caller at edge+1; checked at edge+2, then clocked.
    task automatic cycle(input string tag);
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; wr_addr = '0; wr_data = '0;
        rsv_valid = 0; rsv_addr = '0; clr_req = 0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic read_all(input string tag);
        idle_inputs();
        for (int k = 0; k < int'(NUM_REGS); k += 2) begin
            set_rd(k, k + 1);
            cycle(tag);
        end
    endtask

    int busy_cnt;

    initial begin
        rst = 1'b1;
        idle_inputs();
        set_rd(0, 1);
        model_reset();
        #12;
        check_outputs("in_reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        read_all("after_reset");

        // Write with same-cycle bypass, then registered read
        we = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rd(5, 5);
        cycle("bypass");
        check("bypass_seen", 64'(rd_data[31:0]), 64'hDEADBEEF);
        idle_inputs(); set_rd(5, 6);
        cycle("after_wr");

        // Zero register ignores writes and reservations
        we = 1; wr_addr = 0; wr_data = 32'h12345678;
        rsv_valid = 1; rsv_addr = 0; set_rd(0, 0);
        cycle("zero_wr");
        idle_inputs(); set_rd(0, 0);
        cycle("zero_rd");

        // Scoreboard: reserve, retire, simultaneous reserve + retire
        rsv_valid = 1; rsv_addr = 7; set_rd(7, 6);
        cycle("rsv7");
        idle_inputs(); set_rd(7, 7);
        cycle("pend7");
        we = 1; wr_addr = 7; wr_data = 32'h11;
        cycle("retire7");
        idle_inputs();
        cycle("pend7_clr");
        we = 1; wr_addr = 7; wr_data = 32'hAA; rsv_valid = 1; rsv_addr = 7;
        cycle("rsv_wr7");
        idle_inputs();
        cycle("rsv_wr7_after");

        // Preload for the sweep, leaving regs 3, 12, 20 pending
        for (int r = 1; r < int'(NUM_REGS); r++) begin
            we = 1; wr_addr = AW'(r); wr_data = 32'hA500_0000 | 32'(r);
            rsv_valid = (r == 4 || r == 13 || r == 21);
            rsv_addr  = AW'(r - 1);
            set_rd(r, r - 1);
            cycle("preload");
        end
        idle_inputs(); set_rd(3, 12);
        cycle("preload_pend");

        // Clear sweep with a lost write and an ignored second request
        clr_req = 1; we = 1; wr_addr = 2; wr_data = 32'h77; set_rd(3, 2);
        cycle("clr_start");
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            idle_inputs();
            if (c == 5) begin we = 1; wr_addr = 9; wr_data = 32'h55; rsv_valid = 1; rsv_addr = 9; end
            if (c == 12) clr_req = 1;
            set_rd($urandom_range(0, 31), (c == 6) ? 9 : 3);
            if (clr_busy) busy_cnt++;
            cycle("sweep");
        end
        check("busy_len", 64'(busy_cnt), 64'd32);
        read_all("after_sweep");

        // Asynchronous reset in the middle of a sweep
        for (int r = 1; r < 8; r++) begin
            we = 1; wr_addr = AW'(r); wr_data = 32'(r * 3 + 1); set_rd(r, 0);
            cycle("preload2");
        end
        idle_inputs(); clr_req = 1;
        cycle("clr2");
        idle_inputs(); set_rd(20, 21);
        for (int c = 0; c < 10; c++) cycle("sweep2");
        rst = 1'b1;
        #1;
        model_reset();
        set_rd(25, 30);
        #1;
        check_outputs("async_rst");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        read_all("after_async_rst");
        clr_req = 1;
        cycle("clr3");
        idle_inputs();
        check("clr3_busy", 64'(clr_busy), 64'd1);
        for (int c = 0; c < 34; c++) cycle("sweep3");

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            we        = ($urandom_range(0, 2) != 0);
            wr_addr   = AW'($urandom_range(0, 31));
            wr_data   = $urandom;
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 31));
            clr_req   = ($urandom_range(0, 79) == 0);
            set_rd(($urandom_range(0, 1) != 0) ? int'(wr_addr) : int'($urandom_range(0, 31)),
                   $urandom_range(0, 31));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
